// File: rtl/pc_unit.sv
// Program-counter unit with hold/step/branch/jump, call/return through a
// circular return-address stack, trap redirection and sticky stack-fault flags.
module pc_unit #(
  parameter int unsigned          WIDTH          = 32,
  parameter logic [WIDTH-1:0]     PC_RESET_VALUE = WIDTH'(32'h80000000),
  parameter logic [WIDTH-1:0]     TRAP_VECTOR    = WIDTH'(32'h80000100),
  parameter int unsigned          RAS_DEPTH      = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [2:0]                   PS,
  input  logic [WIDTH-3:0]             in,
  input  logic                         trap,
  input  logic                         flag_clr,
  output logic [WIDTH-1:0]             Q,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_overflow,
  output logic                         ras_underflow
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

  typedef enum logic [2:0] {
    OP_HOLD   = 3'b000,
    OP_STEP   = 3'b001,
    OP_BRANCH = 3'b010,
    OP_JUMP   = 3'b011,
    OP_CALL   = 3'b100,
    OP_RET    = 3'b101,
    OP_RCALL  = 3'b110,
    OP_RSVD   = 3'b111
  } op_e;

  op_e              op;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pc_n, tgt_abs, tgt_rel;
  logic [PW-1:0]    top_q, top_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             push_en;
  logic [WIDTH-1:0] ras_mem_q [RAS_DEPTH];

  assign op      = op_e'(PS);
  assign pc_n    = pc_q + WIDTH'(4);
  // {in,2'b00} is both the absolute word address and the sign-extended byte offset
  assign tgt_abs = {in, 2'b00};
  assign tgt_rel = pc_q + tgt_abs;

  always_comb begin
    pc_d    = pc_q;
    top_d   = top_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q & ~flag_clr;
    unf_d   = unf_q & ~flag_clr;
    push_en = 1'b0;
    if (trap) begin
      pc_d  = TRAP_VECTOR;
      ovf_d = ovf_q;
      unf_d = unf_q;
    end else begin
      case (op)
        OP_STEP:   pc_d = pc_n;
        OP_BRANCH: pc_d = tgt_rel;
        OP_JUMP:   pc_d = tgt_abs;
        OP_CALL: begin
          push_en = 1'b1;
          pc_d    = tgt_abs;
        end
        OP_RCALL: begin
          push_en = 1'b1;
          pc_d    = tgt_rel;
        end
        OP_RET: begin
          if (cnt_q != '0) begin
            pc_d  = ras_mem_q[top_q];
            top_d = top_q - PW'(1);
            cnt_d = cnt_q - CW'(1);
          end else begin
            pc_d  = pc_n;
            unf_d = 1'b1;
          end
        end
        default: ;
      endcase
      // When full, top+1 is the oldest slot, so overwrite and advance alike
      if (push_en) begin
        top_d = top_q + PW'(1);
        if (cnt_q == FULL) ovf_d = 1'b1;
        else               cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q  <= PC_RESET_VALUE;
      top_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      top_q <= top_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && push_en) ras_mem_q[top_d] <= pc_n;
  end

  assign Q             = pc_q;
  assign ras_count     = cnt_q;
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning program-counter width in bits, minimum 8.
REQ-002 The block SHALL have parameter PC_RESET_VALUE, default 32'h80000000 truncated to WIDTH, meaning the Q value after reset.
REQ-003 The block SHALL have parameter TRAP_VECTOR, default 32'h80000100 truncated to WIDTH, meaning the trap target address.
REQ-004 The block SHALL have parameter RAS_DEPTH, default 8, meaning return-address-stack entries, a power of 2 and at least 2.
REQ-005 The block SHALL have port clock  input  1  the only clock, with all state updated on its rising edge.
REQ-006 The block SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-007 The block SHALL have port PS  input  3  operation select.
REQ-008 The block SHALL have port in  input  WIDTH-2  word address or signed word offset.
REQ-009 The block SHALL have port trap  input  1  take-trap request.
REQ-010 The block SHALL have port flag_clr  input  1  clears the sticky flags.
REQ-011 The block SHALL have port Q  output  WIDTH  current PC, registered.
REQ-012 The block SHALL have port ras_count  output  clog2(RAS_DEPTH)+1  number of valid stack entries.
REQ-013 The block SHALL have port ras_overflow  output  1  sticky flag: a push occurred while the stack was full.
REQ-014 The block SHALL have port ras_underflow  output  1  sticky flag: a pop occurred while the stack was empty.

Function
REQ-015 All arithmetic SHALL be modulo 2^WIDTH, with silent wrap and no flag.
REQ-016 The following definitions SHALL apply: A = {in,2'b00}; R = sign-extend(in) shifted left 2, WIDTH bits; N = Q+4.
REQ-017 PS=000 (hold) SHALL leave Q unchanged.
REQ-018 PS=001 (step) SHALL set Q to N.
REQ-019 PS=010 (branch) SHALL set Q to Q+R.
REQ-020 PS=011 (jump) SHALL set Q to A.
REQ-021 PS=100 (call) SHALL push N and set Q to A.
REQ-022 PS=101 (return) SHALL pop the top entry into Q.
REQ-023 PS=110 (relative call) SHALL push N and set Q to Q+R.
REQ-024 PS=111 SHALL be reserved and SHALL behave as hold.
REQ-025 Every operation SHALL have 1-cycle latency: the result is visible on Q after the same rising edge.
REQ-026 The stack SHALL be LIFO, implemented as a circular buffer with a top pointer and a count.
REQ-027 A push when count < RAS_DEPTH SHALL write N at top+1 and increment count.
REQ-028 A push when count == RAS_DEPTH SHALL overwrite the oldest entry (which becomes the new top), hold count at RAS_DEPTH, and set ras_overflow.
REQ-029 A pop when count > 0 SHALL load Q from top, move top back one entry, and decrement count.
REQ-030 A pop when count == 0 SHALL set Q to N, leave count at 0, and set ras_underflow.
REQ-031 trap=1 SHALL override PS: Q is set to TRAP_VECTOR and the stack, count and flags are unchanged for that operation.
REQ-032 flag_clr=1 SHALL clear both sticky flags on that edge.
REQ-033 When flag_clr=1 coincides with a new overflow or underflow, the set SHALL win.
REQ-034 ras_count, ras_overflow and ras_underflow SHALL be registered outputs.
REQ-035 Stack entry contents SHALL not be observable except through a return.

Reset
REQ-036 reset=1 SHALL immediately, without waiting for a clock edge, force Q=PC_RESET_VALUE, ras_count=0, the top pointer to 0, ras_overflow=0 and ras_underflow=0.
REQ-037 While reset=1, all inputs SHALL be ignored.
REQ-038 Stack entry RAM need not be reset.
REQ-039 Reset asserted mid-sequence SHALL discard all pending stack content; a return after reset is an underflow.
REQ-040 The first operation after reset deasserts SHALL act on PC_RESET_VALUE.

Verification
REQ-041 The bench SHALL cover: reset, then PS=001 for 3 cycles -> Q=80000000, 80000004, 80000008, 8000000C.
REQ-042 The bench SHALL cover: from Q=80000010, PS=010 with in=all-ones (-1) -> Q=8000000C; then PS=010 with in=3 -> Q=80000018.
REQ-043 The bench SHALL cover: from Q=80000000, PS=100 with in=0x0000040 -> Q=00000100 and ras_count=1; then PS=101 -> Q=80000004 and ras_count=0.
REQ-044 The bench SHALL cover: 9 calls with RAS_DEPTH=8 -> ras_count=8 and ras_overflow=1; then 8 returns -> Q equals the return addresses of calls 9 down to 2; then a 9th return -> underflow set and Q = previous Q+4.
REQ-045 The bench SHALL cover: trap=1 together with PS=100 -> Q=80000100 and ras_count unchanged; flag_clr=1 together with an underflowing return -> ras_underflow stays 1.
REQ-046 The bench SHALL cover: reset pulsed between clock edges while ras_count=3 -> Q=80000000 and ras_count=0 before the next edge; Q=FFFFFFFC with PS=001 -> Q=00000000 (wrap).
